// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the MIPS fetch/IR stage: fetch FSM states,
// branch opcodes recognised by the predecoder and the default reset PC.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_e;

  localparam logic [5:0]  OP_BEQ           = 6'b000100;
  localparam logic [5:0]  OP_BNE           = 6'b000101;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/signext.sv
// 16-to-32-bit sign extender (shared with the execute-stage immediate path).
module signext (
  input  logic [15:0] a,
  output logic [31:0] y
);

  assign y = {{16{a[15]}}, a};

endmodule

// File: rtl/fetch_ir_stage.sv
// Multicycle instruction-fetch stage: owns the PC, runs a req/ack handshake
// to instruction memory and holds the fetched word in the IR until consumed.
// Optional feature macro: BRANCH_PREDECODE_EN (beq/bne detect + target adder).
module fetch_ir_stage
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        ir_valid,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic [31:0] pc_plus4,
  output logic [15:0] imm16,
  output logic [31:0] br_target,
  output logic        is_branch
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic [31:0]  ir_pc_q, ir_pc_d;
  logic         ir_valid_q, ir_valid_d;
  logic [31:0]  flush_addr_q, flush_addr_d;
  logic [31:0]  redirect_pc;
  logic [1:0]   unused_target_lsbs;

  assign redirect_pc        = {redirect_target[31:2], 2'b00};
  assign unused_target_lsbs = redirect_target[1:0];

  // State, PC and IR registers; reset is asynchronous so imem_req drops at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      ir_q         <= 32'h0;
      ir_pc_q      <= 32'h0;
      ir_valid_q   <= 1'b0;
      flush_addr_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      ir_pc_q      <= ir_pc_d;
      ir_valid_q   <= ir_valid_d;
      flush_addr_q <= flush_addr_d;
    end
  end

  // Next-state logic; redirect overrides stall and ack handling in every state.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    ir_pc_d      = ir_pc_q;
    ir_valid_d   = ir_valid_q;
    flush_addr_d = flush_addr_q;
    imem_req     = 1'b0;
    if (redirect) begin
      pc_d       = redirect_pc;
      ir_valid_d = 1'b0;
    end
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        imem_req = 1'b1;
        if (redirect) begin
          // Outstanding request cannot be withdrawn: remember its address
          // and wait for its (discarded) ack unless it lands right now.
          if (imem_ack) begin
            state_d = ST_REQ;
          end else begin
            state_d      = ST_FLUSH;
            flush_addr_d = pc_q;
          end
        end else if (imem_ack) begin
          ir_d       = imem_rdata;
          ir_pc_d    = pc_q;
          pc_d       = pc_q + 32'd4;
          ir_valid_d = 1'b1;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect || !stall) begin
          ir_valid_d = 1'b0;
          state_d    = ST_REQ;
        end
      end
      ST_FLUSH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign imem_addr = (state_q == ST_FLUSH) ? flush_addr_q : pc_q;
  assign ir_valid  = ir_valid_q;
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;
  assign pc_plus4  = ir_pc_q + 32'd4;
  assign imm16     = ir_q[15:0];

`ifdef BRANCH_PREDECODE_EN
  logic [31:0] imm_ext;

  signext u_signext (
    .a (ir_q[15:0]),
    .y (imm_ext)
  );

  assign is_branch = ir_valid_q && ((ir_q[31:26] == OP_BEQ) || (ir_q[31:26] == OP_BNE));
  assign br_target = pc_plus4 + {imm_ext[29:0], 2'b00};
`else
  assign is_branch = 1'b0;
  assign br_target = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_ir_stage.sv
module tb_fetch_ir_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack, stall, redirect, ir_valid, is_branch;
  logic [31:0] imem_addr, imem_rdata, redirect_target, ir, ir_pc, pc_plus4, br_target;
  logic [15:0] imm16;

  // second instance: wrap-around of the PC from the top of memory
  logic        req2, ack2, ir_valid2, is_branch2;
  logic        stall2 = 1'b0;
  logic        redirect2 = 1'b0;
  logic [31:0] addr2, ir2, ir_pc2, pc_plus4_2, br_target2;
  logic [31:0] rdata2 = 32'hDEAD_BEEF;
  logic [31:0] target2 = 32'h0;
  logic [15:0] imm16_2;

  int passed = 0;
  int total  = 0;

  // behavioural model: transaction-level view of the fetch stage
  logic        m_dead;     // dead cycle after reset release
  logic        m_req;      // a request is outstanding
  logic        m_drop;     // outstanding request's data must be thrown away
  logic [31:0] m_addr;     // address of outstanding request
  logic [31:0] m_pc;
  logic [31:0] m_ir, m_irpc;
  logic        m_valid;

  always #5 clk = ~clk;

  fetch_ir_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
    .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc), .pc_plus4(pc_plus4), .imm16(imm16),
    .br_target(br_target), .is_branch(is_branch)
  );

  fetch_ir_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(rst_n),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_rdata(rdata2),
    .stall(stall2), .redirect(redirect2), .redirect_target(target2),
    .ir_valid(ir_valid2), .ir(ir2), .ir_pc(ir_pc2), .pc_plus4(pc_plus4_2), .imm16(imm16_2),
    .br_target(br_target2), .is_branch(is_branch2)
  );

  assign ack2 = req2;  // zero-wait memory

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] model_br_target(input logic [31:0] ir_w, input logic [31:0] pc_w);
    int signed off;
    off = $signed(ir_w[15:0]) * 4;
    return pc_w + 32'd4 + 32'(off);
  endfunction

  // compare every DUT output against the model
  task automatic compare_all();
    logic exp_br;
    chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
    if (m_req) chk("imem_addr", imem_addr, m_addr);
    chk("ir_valid", {31'b0, ir_valid}, {31'b0, m_valid});
    chk("ir", ir, m_ir);
    chk("ir_pc", ir_pc, m_irpc);
    chk("pc_plus4", pc_plus4, m_irpc + 32'd4);
    chk("imm16", {16'b0, imm16}, {16'b0, m_ir[15:0]});
`ifdef BRANCH_PREDECODE_EN
    exp_br = m_valid && (m_ir[31:26] == 6'd4 || m_ir[31:26] == 6'd5);
    chk("is_branch", {31'b0, is_branch}, {31'b0, exp_br});
    chk("br_target", br_target, model_br_target(m_ir, m_irpc));
`else
    exp_br = 1'b0;
    chk("is_branch", {31'b0, is_branch}, {31'b0, exp_br});
    chk("br_target", br_target, 32'h0);
`endif
  endtask

  // advance the model by one clock using the inputs just applied
  task automatic model_step(input logic r, input logic [31:0] t, input logic a,
                            input logic [31:0] d, input logic s);
    logic [31:0] tgt;
    tgt = {t[31:2], 2'b00};
    if (m_dead) begin
      m_dead = 1'b0;
      if (r) m_pc = tgt;
      m_req = 1'b1; m_drop = 1'b0; m_addr = m_pc;
    end else if (m_req) begin
      if (a) begin
        if (!m_drop && !r) begin
          m_ir = d; m_irpc = m_addr; m_pc = m_addr + 32'd4; m_valid = 1'b1; m_req = 1'b0;
        end else begin
          if (r) m_pc = tgt;
          m_valid = 1'b0; m_drop = 1'b0; m_addr = m_pc;
        end
      end else if (r) begin
        m_pc = tgt; m_drop = 1'b1; m_valid = 1'b0;
      end
    end else begin
      if (r) m_pc = tgt;
      if (r || !s) begin
        m_valid = 1'b0; m_req = 1'b1; m_drop = 1'b0; m_addr = m_pc;
      end
    end
  endtask

  // apply inputs (called just after a falling edge), clock, then check
  task automatic step(input logic r, input logic [31:0] t, input logic a,
                      input logic [31:0] d, input logic s);
    redirect = r; redirect_target = t; imem_ack = a; imem_rdata = d; stall = s;
    @(posedge clk);
    model_step(r, t, a, d, s);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst_n = 1'b1;
    imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_ir_pc", ir_pc, 32'h0);
    chk("rst_ir_valid", {31'b0, ir_valid}, 32'h0);
    chk("rst_is_branch", {31'b0, is_branch}, 32'h0);
    chk("rst_br_target", br_target, 32'h0);
    m_dead = 1'b1; m_req = 1'b0; m_drop = 1'b0; m_addr = 32'h0; m_pc = 32'h0;
    m_ir = 32'h0; m_irpc = 32'h0; m_valid = 1'b0;
    rst_n = 1'b1;
    chk("idle_req", {31'b0, imem_req}, 32'h0);

    // first request after the dead cycle; wrap instance acks immediately
    step(0, 0, 0, 0, 0);
    chk("first_req", {31'b0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
    step(0, 0, 1, 32'h1234_5678, 0);
    chk("ir_load", ir, 32'h1234_5678);
    chk("ir_valid_load", {31'b0, ir_valid}, 32'h1);
    chk("imm16_load", {16'b0, imm16}, 32'h5678);
    chk("ir_pc_load", ir_pc, 32'h0);
    chk("pc_plus4_load", pc_plus4, 32'h4);
    chk("wrap_pc_plus4", pc_plus4_2, 32'h0);
    step(0, 0, 0, 0, 0);
    chk("second_addr", imem_addr, 32'h4);
    chk("second_req", {31'b0, imem_req}, 32'h1);
    chk("wrap_addr1", addr2, 32'h0);
    chk("wrap_req1", {31'b0, req2}, 32'h1);

    // delayed ack, then stall held for 5 cycles
    repeat (3) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 32'hA5A5_0011, 1);
    repeat (5) begin
      step(0, 0, 0, 0, 1);
      chk("stall_noreq", {31'b0, imem_req}, 32'h0);
      chk("stall_ir", ir, 32'hA5A5_0011);
    end
    step(0, 0, 0, 0, 0);
    chk("after_stall_addr", imem_addr, 32'h8);

    // redirect while waiting for ack
    step(1, 32'h0000_0103, 0, 0, 0);
    chk("flush_addr", imem_addr, 32'h8);
    chk("flush_req", {31'b0, imem_req}, 32'h1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 32'hBAD0_BAD0, 0);
    chk("flush_ir_kept", ir, 32'hA5A5_0011);
    chk("redir_addr", imem_addr, 32'h100);

    // redirect coinciding with ack
    step(1, 32'h0000_0103, 1, 32'hBAD1_BAD1, 0);
    chk("redir_ack_ir", ir, 32'hA5A5_0011);
    chk("redir_ack_addr", imem_addr, 32'h100);
    step(0, 0, 1, 32'h0000_0777, 1);

    // branch predecode (HOLD -> redirect to 0x40)
    step(1, 32'h0000_0040, 0, 0, 1);
    step(0, 0, 1, 32'h1000_FFFF, 1);
    chk("bq_ir_pc", ir_pc, 32'h40);
`ifdef BRANCH_PREDECODE_EN
    chk("bq_is_branch", {31'b0, is_branch}, 32'h1);
    chk("bq_target_m1", br_target, 32'h40);
`else
    chk("bq_is_branch_off", {31'b0, is_branch}, 32'h0);
    chk("bq_target_off", br_target, 32'h0);
`endif
    step(1, 32'h0000_0040, 0, 0, 1);
    step(0, 0, 1, 32'h1000_0001, 1);
`ifdef BRANCH_PREDECODE_EN
    chk("bq_target_p1", br_target, 32'h48);
`else
    chk("bq_target_p1_off", br_target, 32'h0);
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic        r, a, s;
      logic [31:0] t, d;
      r = ($urandom_range(0, 9) == 0);
      t = $urandom;
      a = m_req && ($urandom_range(0, 2) == 0);
      s = ($urandom_range(0, 1) == 0);
      d = $urandom;
      if ($urandom_range(0, 3) == 0) d[31:26] = $urandom_range(0, 1) ? 6'b000100 : 6'b000101;
      step(r, t, a, d, s);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
